rtc_core: RTL and testbench
===========================

RTC_CORE -- requirements
Module: rtc_core

Interface
REQ-001 Parameter CLK_HZ, default 100000000, clk cycles per second; benches use 4.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 run  in  1  counting enable; low while any edit state is active.
REQ-005 load  in  1  one-cycle strobe that commits all *_bcd_in fields.
REQ-006 year_bcd_in  in  16; month_bcd_in, day_bcd_in, hour_bcd_in, minute_bcd_in, second_bcd_in  in  8 each; packed-BCD values from the editor.
REQ-007 year_bcd  out  16; month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd  out  8 each; current registered BCD time and date.
REQ-008 sec_pulse  out  1  high for exactly one cycle on each one-second advance.

Function
REQ-009 The prescaler SHALL count 0..CLK_HZ-1 while run=1, hold its value while run=0, and assert an internal advance in the cycle it equals CLK_HZ-1, then wrap to 0.
REQ-010 Advance SHALL increment second_bcd in BCD, with x9 going to (x+1)0 and 59 going to 00 plus a carry to minutes.
REQ-011 Minutes SHALL roll 59 to 00 with a carry to hours; hours SHALL roll 23 to 00 with a carry to day.
REQ-012 Day SHALL roll from days_in_month(month_bcd, year_bcd) to 01 with a carry to month; month SHALL roll 12 to 01 with a carry to year; year SHALL roll 9999 to 0000.
REQ-013 All carries SHALL resolve in the same cycle: the full cascade updates on one edge, and 1-cycle latency applies from advance to outputs.
REQ-014 days_in_month SHALL be 31 for months 01/03/05/07/08/10/12, 30 for 04/06/09/11, and 28 or 29 for 02 (see REQ-022).
REQ-015 sec_pulse SHALL be the registered advance, coincident with the new second_bcd value.
REQ-016 With load=1, all six outputs SHALL take *_bcd_in on the next edge, the prescaler SHALL clear to 0, and no advance SHALL occur in that cycle.
REQ-017 Load SHALL take priority over a simultaneous advance; the advance is dropped and sec_pulse stays low.
REQ-018 A loaded day above days_in_month(month_bcd_in, year_bcd_in) SHALL be clamped to that maximum; a loaded day of 00 SHALL become 01.
REQ-019 Load SHALL act regardless of run.

Reset
REQ-020 With rst asserted, outputs SHALL be: year_bcd=16'h2000, month_bcd=8'h01, day_bcd=8'h01, hour_bcd=minute_bcd=second_bcd=8'h00, sec_pulse=0, prescaler=0.
REQ-021 Reset mid-cascade or mid-load SHALL discard the pending update; counting SHALL resume from the reset values on the first edge after rst deasserts with run=1.

Configuration
REQ-022 With RTC_LEAP_YEAR_EN defined, February SHALL have 29 days when the year is divisible by 4 and either not divisible by 100 or divisible by 400; all tests SHALL be done on BCD digits without binary conversion. Without the macro, February SHALL always have 28 days.

Structure
REQ-023 The shared package clock_pkg SHALL hold the BCD field limits (8'h59, 8'h23, 8'h12, 16'h9999) and the month codes.
REQ-024 A combinational sub-module bcd_days_in_month SHALL take (month_bcd, year_bcd) and return the maximum day in BCD; it is instantiated twice, once for counting and once for load clamping.

Verification
REQ-025 Assert then release rst with run=1 and CLK_HZ=4 -> outputs 2000-01-01 00:00:00; after 4 cycles second_bcd=01 and one sec_pulse.
REQ-026 Load 2023-12-31 23:59:59, then one advance -> 2024-01-01 00:00:00 on a single edge.
REQ-027 Load 2024-02-28 23:59:59 and advance -> 2024-02-29 with the macro, 2024-03-01 without it; load 2100-02-28 23:59:59 and advance -> 2100-03-01 in both builds.
REQ-028 Load 2023-04-31 -> day_bcd=30; load day 00 -> day_bcd=01.
REQ-029 Assert load in the same cycle the prescaler reaches CLK_HZ-1 -> loaded values appear with no increment and no sec_pulse; the next advance occurs exactly CLK_HZ cycles later.
REQ-030 Drop run for 10 cycles mid-count -> outputs and prescaler frozen; load 9999-12-31 23:59:59, set run=1, and advance -> 0000-01-01 00:00:00.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared BCD calendar limits, month codes and digit helpers for the RTC.
// The leap-year helper is only used when RTC_LEAP_YEAR_EN is defined.
package clock_pkg;

    localparam logic [7:0]  SEC_MAX   = 8'h59;
    localparam logic [7:0]  MIN_MAX   = 8'h59;
    localparam logic [7:0]  HOUR_MAX  = 8'h23;
    localparam logic [7:0]  MONTH_MAX = 8'h12;
    localparam logic [7:0]  DAY_MIN   = 8'h01;
    localparam logic [15:0] YEAR_MAX  = 16'h9999;

    localparam logic [15:0] RST_YEAR  = 16'h2000;
    localparam logic [7:0]  RST_MONTH = 8'h01;
    localparam logic [7:0]  RST_DAY   = 8'h01;

    typedef enum logic [7:0] {
        MONTH_JAN = 8'h01, MONTH_FEB = 8'h02, MONTH_MAR = 8'h03,
        MONTH_APR = 8'h04, MONTH_MAY = 8'h05, MONTH_JUN = 8'h06,
        MONTH_JUL = 8'h07, MONTH_AUG = 8'h08, MONTH_SEP = 8'h09,
        MONTH_OCT = 8'h10, MONTH_NOV = 8'h11, MONTH_DEC = 8'h12
    } month_e;

    // Two-digit BCD increment; callers handle the wrap at their own limit.
    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'h9) begin
            r = {v[7:4] + 4'h1, 4'h0};
        end else begin
            r = {v[7:4], v[3:0] + 4'h1};
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v[7:0] == 8'h99) begin
            r = {bcd_inc8(v[15:8]), 8'h00};
        end else begin
            r = {v[15:8], bcd_inc8(v[7:0])};
        end
        return r;
    endfunction

    // 10t+o is divisible by 4 exactly when 2t+o is: even tens need o in {0,4,8}, odd tens o in {2,6}.
    function automatic logic bcd_div4(input logic [7:0] v);
        logic r;
        case (v[3:0])
            4'h0, 4'h4, 4'h8: r = ~v[4];
            4'h2, 4'h6:       r = v[4];
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bcd_days_in_month.sv
// Combinational maximum day (BCD) of a month; February gets 29 in leap years
// only when RTC_LEAP_YEAR_EN is defined, all arithmetic done on BCD digits.
module bcd_days_in_month
    import clock_pkg::*;
(
    input  logic [7:0]  month_bcd,
    input  logic [15:0] year_bcd,
    output logic [7:0]  max_day
);

    logic leap_s;

`ifdef RTC_LEAP_YEAR_EN
    // Century years are leap only when the century digits divide by 4.
    always_comb begin
        if (year_bcd[7:0] == 8'h00) begin
            leap_s = bcd_div4(year_bcd[15:8]);
        end else begin
            leap_s = bcd_div4(year_bcd[7:0]);
        end
    end
`else
    logic unused_year_s;
    assign unused_year_s = ^year_bcd;
    assign leap_s        = 1'b0;
`endif

    // Month length lookup; out-of-range months fall back to 31.
    always_comb begin
        max_day = 8'h31;
        case (month_bcd)
            MONTH_JAN, MONTH_MAR, MONTH_MAY, MONTH_JUL,
            MONTH_AUG, MONTH_OCT, MONTH_DEC:             max_day = 8'h31;
            MONTH_APR, MONTH_JUN, MONTH_SEP, MONTH_NOV:  max_day = 8'h30;
            MONTH_FEB:                                   max_day = leap_s ? 8'h29 : 8'h28;
            default:                                     max_day = 8'h31;
        endcase
    end

endmodule

// File: rtl/rtc_core.sv
// BCD real-time clock: prescaler, single-edge full carry cascade and loader.
// Leap-year February is enabled by defining RTC_LEAP_YEAR_EN.
module rtc_core
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        load,
    input  logic [15:0] year_bcd_in,
    input  logic [7:0]  month_bcd_in,
    input  logic [7:0]  day_bcd_in,
    input  logic [7:0]  hour_bcd_in,
    input  logic [7:0]  minute_bcd_in,
    input  logic [7:0]  second_bcd_in,
    output logic [15:0] year_bcd,
    output logic [7:0]  month_bcd,
    output logic [7:0]  day_bcd,
    output logic [7:0]  hour_bcd,
    output logic [7:0]  minute_bcd,
    output logic [7:0]  second_bcd,
    output logic        sec_pulse
);

    localparam int            PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_r;
    logic [15:0]   year_r;
    logic [7:0]    month_r, day_r, hour_r, minute_r, second_r;
    logic          sec_pulse_r;

    logic [7:0]    max_day_cnt_s, max_day_ld_s, load_day_s;
    logic          min_step_s, hour_step_s, day_step_s, month_step_s, year_step_s;
    logic [15:0]   year_nxt_s;
    logic [7:0]    month_nxt_s, day_nxt_s, hour_nxt_s, minute_nxt_s, second_nxt_s;

    bcd_days_in_month u_dim_cnt (
        .month_bcd (month_r),
        .year_bcd  (year_r),
        .max_day   (max_day_cnt_s)
    );

    bcd_days_in_month u_dim_ld (
        .month_bcd (month_bcd_in),
        .year_bcd  (year_bcd_in),
        .max_day   (max_day_ld_s)
    );

    // Carry chain: each field steps only when every lower field wraps this second.
    always_comb begin
        min_step_s   = (second_r == SEC_MAX);
        hour_step_s  = min_step_s  && (minute_r == MIN_MAX);
        day_step_s   = hour_step_s && (hour_r == HOUR_MAX);
        month_step_s = day_step_s  && (day_r >= max_day_cnt_s);
        year_step_s  = month_step_s && (month_r >= MONTH_MAX);

        second_nxt_s = min_step_s ? 8'h00 : bcd_inc8(second_r);
        minute_nxt_s = hour_step_s ? 8'h00 : (min_step_s ? bcd_inc8(minute_r) : minute_r);
        hour_nxt_s   = day_step_s ? 8'h00 : (hour_step_s ? bcd_inc8(hour_r) : hour_r);
        day_nxt_s    = month_step_s ? DAY_MIN : (day_step_s ? bcd_inc8(day_r) : day_r);
        month_nxt_s  = year_step_s ? RST_MONTH : (month_step_s ? bcd_inc8(month_r) : month_r);
        if (year_step_s) begin
            year_nxt_s = (year_r == YEAR_MAX) ? 16'h0000 : bcd_inc16(year_r);
        end else begin
            year_nxt_s = year_r;
        end
    end

    // Loaded day is clamped into 01..days_in_month of the loaded month/year.
    always_comb begin
        if (day_bcd_in > max_day_ld_s) begin
            load_day_s = max_day_ld_s;
        end else if (day_bcd_in == 8'h00) begin
            load_day_s = DAY_MIN;
        end else begin
            load_day_s = day_bcd_in;
        end
    end

    // Time registers: load wins over advance; prescaler holds while run is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r     <= '0;
            year_r      <= RST_YEAR;
            month_r     <= RST_MONTH;
            day_r       <= RST_DAY;
            hour_r      <= 8'h00;
            minute_r    <= 8'h00;
            second_r    <= 8'h00;
            sec_pulse_r <= 1'b0;
        end else if (load) begin
            presc_r     <= '0;
            year_r      <= year_bcd_in;
            month_r     <= month_bcd_in;
            day_r       <= load_day_s;
            hour_r      <= hour_bcd_in;
            minute_r    <= minute_bcd_in;
            second_r    <= second_bcd_in;
            sec_pulse_r <= 1'b0;
        end else if (run && (presc_r == PRESC_MAX)) begin
            presc_r     <= '0;
            year_r      <= year_nxt_s;
            month_r     <= month_nxt_s;
            day_r       <= day_nxt_s;
            hour_r      <= hour_nxt_s;
            minute_r    <= minute_nxt_s;
            second_r    <= second_nxt_s;
            sec_pulse_r <= 1'b1;
        end else if (run) begin
            presc_r     <= presc_r + PW'(1);
            sec_pulse_r <= 1'b0;
        end else begin
            sec_pulse_r <= 1'b0;
        end
    end

    assign year_bcd   = year_r;
    assign month_bcd  = month_r;
    assign day_bcd    = day_r;
    assign hour_bcd   = hour_r;
    assign minute_bcd = minute_r;
    assign second_bcd = second_r;
    assign sec_pulse  = sec_pulse_r;

endmodule

// File: tb/tb_rtc_core.sv
// Scoreboard bench for rtc_core with CLK_HZ=4; expectations are queued as
// stimulus is driven and popped when the outputs are sampled.
module tb_rtc_core;

    logic        clk = 1'b0;
    logic        rst, run, load;
    logic [15:0] year_in, year_bcd;
    logic [7:0]  month_in, day_in, hour_in, minute_in, second_in;
    logic [7:0]  month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd;
    logic        sec_pulse;

    typedef struct {
        string       tag;
        logic [55:0] t;
        logic        p;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    localparam logic [55:0] T_RST = 56'h2000_01_01_00_00_00;

    rtc_core #(.CLK_HZ(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .load          (load),
        .year_bcd_in   (year_in),
        .month_bcd_in  (month_in),
        .day_bcd_in    (day_in),
        .hour_bcd_in   (hour_in),
        .minute_bcd_in (minute_in),
        .second_bcd_in (second_in),
        .year_bcd      (year_bcd),
        .month_bcd     (month_bcd),
        .day_bcd       (day_bcd),
        .hour_bcd      (hour_bcd),
        .minute_bcd    (minute_bcd),
        .second_bcd    (second_bcd),
        .sec_pulse     (sec_pulse)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string tag, input logic [55:0] t, input logic p);
        exp_t e;
        e.tag = tag;
        e.t   = t;
        e.p   = p;
        sb_q.push_back(e);
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check_val({e.tag, "_time"},
                      {8'h00, year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd}, {8'h00, e.t});
            check_val({e.tag, "_pulse"}, {63'd0, sec_pulse}, {63'd0, e.p});
        end
    endtask

    task automatic drive_in(input logic [55:0] t);
        year_in   = t[55:40];
        month_in  = t[39:32];
        day_in    = t[31:24];
        hour_in   = t[23:16];
        minute_in = t[15:8];
        second_in = t[7:0];
    endtask

    task automatic do_load(input logic [55:0] t);
        drive_in(t);
        load = 1'b1;
        tick(1);
        load = 1'b0;
    endtask

    // Load, expect loaded value, no change for 3 cycles, then one advance.
    task automatic load_adv(input string tag, input logic [55:0] ld, input logic [55:0] nx);
        do_load(ld);
        push_exp({tag, "_ld"}, ld, 1'b0);
        sb_check();
        tick(3);
        push_exp({tag, "_hold"}, ld, 1'b0);
        sb_check();
        tick(1);
        push_exp({tag, "_adv"}, nx, 1'b1);
        sb_check();
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b1;
        load = 1'b0;
        drive_in(56'h0);

        tick(2);
        push_exp("rst", T_RST, 1'b0);
        sb_check();

        rst = 1'b0;
        tick(3);
        push_exp("first_hold", T_RST, 1'b0);
        sb_check();
        tick(1);
        push_exp("first_sec", 56'h2000_01_01_00_00_01, 1'b1);
        sb_check();
        tick(1);
        push_exp("pulse_once", 56'h2000_01_01_00_00_01, 1'b0);
        sb_check();

        load_adv("newyear", 56'h2023_12_31_23_59_59, 56'h2024_01_01_00_00_00);
`ifdef RTC_LEAP_YEAR_EN
        load_adv("leap2024", 56'h2024_02_28_23_59_59, 56'h2024_02_29_00_00_00);
        load_adv("leap2000", 56'h2000_02_28_23_59_59, 56'h2000_02_29_00_00_00);
`else
        load_adv("leap2024", 56'h2024_02_28_23_59_59, 56'h2024_03_01_00_00_00);
        load_adv("leap2000", 56'h2000_02_28_23_59_59, 56'h2000_03_01_00_00_00);
`endif
        load_adv("c2100", 56'h2100_02_28_23_59_59, 56'h2100_03_01_00_00_00);
        load_adv("feb2023", 56'h2023_02_28_23_59_59, 56'h2023_03_01_00_00_00);
        load_adv("apr30", 56'h2023_04_30_23_59_59, 56'h2023_05_01_00_00_00);
        load_adv("hour", 56'h2023_06_15_10_59_59, 56'h2023_06_15_11_00_00);

        do_load(56'h2023_04_31_12_00_00);
        push_exp("clamp_apr", 56'h2023_04_30_12_00_00, 1'b0);
        sb_check();
        do_load(56'h2023_05_00_12_00_00);
        push_exp("clamp_zero", 56'h2023_05_01_12_00_00, 1'b0);
        sb_check();
        do_load(56'h2023_02_30_12_00_00);
        push_exp("clamp_feb", 56'h2023_02_28_12_00_00, 1'b0);
        sb_check();

        // Load lands on the edge where the prescaler would have advanced.
        do_load(56'h2023_01_01_00_00_05);
        push_exp("coll_a", 56'h2023_01_01_00_00_05, 1'b0);
        sb_check();
        tick(3);
        push_exp("coll_a_hold", 56'h2023_01_01_00_00_05, 1'b0);
        sb_check();
        do_load(56'h2023_01_01_00_00_09);
        push_exp("coll_b", 56'h2023_01_01_00_00_09, 1'b0);
        sb_check();
        tick(3);
        push_exp("coll_b_hold", 56'h2023_01_01_00_00_09, 1'b0);
        sb_check();
        tick(1);
        push_exp("coll_b_adv", 56'h2023_01_01_00_00_10, 1'b1);
        sb_check();

        // Freeze with run low, prescaler must resume from where it stopped.
        do_load(56'h2023_07_04_08_30_00);
        tick(2);
        push_exp("frz_pre", 56'h2023_07_04_08_30_00, 1'b0);
        sb_check();
        run = 1'b0;
        tick(10);
        push_exp("frz_hold", 56'h2023_07_04_08_30_00, 1'b0);
        sb_check();
        run = 1'b1;
        tick(1);
        push_exp("frz_resume", 56'h2023_07_04_08_30_00, 1'b0);
        sb_check();
        tick(1);
        push_exp("frz_adv", 56'h2023_07_04_08_30_01, 1'b1);
        sb_check();

        run = 1'b0;
        do_load(56'h9999_12_31_23_59_59);
        push_exp("max_ld", 56'h9999_12_31_23_59_59, 1'b0);
        sb_check();
        tick(5);
        push_exp("max_idle", 56'h9999_12_31_23_59_59, 1'b0);
        sb_check();
        run = 1'b1;
        tick(3);
        push_exp("max_hold", 56'h9999_12_31_23_59_59, 1'b0);
        sb_check();
        tick(1);
        push_exp("max_wrap", 56'h0000_01_01_00_00_00, 1'b1);
        sb_check();

        // Reset during a pending load discards it.
        drive_in(56'h2023_03_03_03_03_03);
        load = 1'b1;
        #2;
        rst = 1'b1;
        tick(1);
        load = 1'b0;
        push_exp("rst_load", T_RST, 1'b0);
        sb_check();
        rst = 1'b0;
        tick(3);
        push_exp("rst_hold", T_RST, 1'b0);
        sb_check();
        tick(1);
        push_exp("rst_adv", 56'h2000_01_01_00_00_01, 1'b1);
        sb_check();

        check_val("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
